input_processor: RTL and testbench

Rate-coding front end of the spiking network: converts each of `INPUT_SIZE` pixel intensities into a spike train on a per-channel binary output. One spike decision per channel is made per "tick", a rising edge of the slow `clk_cnt` strobe. The spike density over a 16-tick window is proportional to pixel intensity. The block sits between the pixel source and the first neuron layer, and all outputs are registered in the `clk` domain.

---
 rtl/input_processor.sv | 85 ++++++++
 tb/tb_input_processor.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/input_processor.sv
// Rate-coding spike generator: each pixel becomes a spike train whose density tracks intensity.
// Define INPUT_PROC_LFSR_EN for stochastic per-channel LFSR coding; the default build uses a shared window counter.
module input_processor #(
  parameter int PIXEL_WIDTH = 8,
  parameter int INPUT_SIZE  = 4,
  parameter int WINDOW_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_cnt,
  input  logic [PIXEL_WIDTH-1:0] pixel_value [INPUT_SIZE],
  output logic                   spike_out   [INPUT_SIZE]
);

  logic                   r_s1;
  logic                   r_s2;
  logic                   r_s3;
  logic                   w_tick;
  logic [WINDOW_BITS-1:0] r_cnt;

  // clk_cnt is asynchronous: two flops for metastability, a third for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= clk_cnt;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_tick = r_s2 & ~r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < INPUT_SIZE; gi++) begin : g_chan
      logic w_full;
      logic w_hit;

      assign w_full = (pixel_value[gi] == {PIXEL_WIDTH{1'b1}});

`ifdef INPUT_PROC_LFSR_EN
      localparam logic [7:0] SEED_RAW = 8'hA5 ^ 8'(gi);
      localparam logic [7:0] SEED     = (SEED_RAW == 8'h00) ? 8'h01 : SEED_RAW;

      logic [7:0] r_lfsr;

      // Fibonacci form of x^8+x^6+x^5+x^4+1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lfsr <= SEED;
        end else if (w_tick) begin
          r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
      end

      assign w_hit = (r_lfsr < pixel_value[gi]);
`else
      logic [WINDOW_BITS-1:0] w_thr;

      assign w_thr = pixel_value[gi][PIXEL_WIDTH-1 -: WINDOW_BITS];
      assign w_hit = (r_cnt < w_thr);
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          spike_out[gi] <= 1'b0;
        end else begin
          spike_out[gi] <= w_full | w_hit;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_input_processor.sv
// Directed self-checking bench for input_processor with six channels.
// Deterministic counter coding by default; LFSR expectations when INPUT_PROC_LFSR_EN is defined.
module tb_input_processor;

  localparam int PW = 8;
  localparam int NCH = 6;

  logic          clk;
  logic          rst_n;
  logic          clk_cnt;
  logic [PW-1:0] pixel [NCH];
  logic          spike [NCH];

  int n_checks = 0;
  int n_fail   = 0;
  int counts [NCH];

  input_processor #(
    .PIXEL_WIDTH(PW),
    .INPUT_SIZE (NCH),
    .WINDOW_BITS(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_cnt    (clk_cnt),
    .pixel_value(pixel),
    .spike_out  (spike)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int spike_vec();
    int v = 0;
    for (int i = 0; i < NCH; i++) v = v | (int'(spike[i]) << i);
    return v;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // advance n rising edges and land 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pixels(input int p0, input int p1, input int p2,
                            input int p3, input int p4, input int p5);
    pixel[0] = 8'(p0); pixel[1] = 8'(p1); pixel[2] = 8'(p2);
    pixel[3] = 8'(p3); pixel[4] = 8'(p4); pixel[5] = 8'(p5);
  endtask

  // each tick: clk_cnt high 3 clocks, low 3 clocks; sample after the counter update has propagated
  task automatic run_ticks(input int n);
    for (int c = 0; c < NCH; c++) counts[c] = 0;
    for (int t = 0; t < n; t++) begin
      clk_cnt = 1'b1;
      step(3);
      clk_cnt = 1'b0;
      step(3);
      for (int c = 0; c < NCH; c++) counts[c] += int'(spike[c]);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    clk_cnt = 1'b0;
    set_pixels(255, 255, 255, 255, 255, 255);
    step(3);
    check("reset_held", spike_vec(), 0);
    rst_n = 1'b1;
    step(1);
    check("reset_release", spike_vec(), 63);

`ifdef INPUT_PROC_LFSR_EN
    set_pixels(128, 0, 255, 0, 0, 0);
    step(1);
    run_ticks(255);
    check("lfsr_p128", int'(counts[0] == 127 || counts[0] == 128), 1);
    check("lfsr_p0", counts[1], 0);
    check("lfsr_p255", counts[2], 255);
`else
    set_pixels(0, 15, 16, 240, 254, 255);
    step(1);
    run_ticks(16);
    check("bnd_p0", counts[0], 0);
    check("bnd_p15", counts[1], 0);
    check("bnd_p16", counts[2], 1);
    check("bnd_p240", counts[3], 15);
    check("bnd_p254", counts[4], 15);
    check("bnd_p255", counts[5], 16);

    set_pixels(32, 64, 128, 255, 0, 0);
    step(1);
    run_ticks(32);
    check("dens_p32", counts[0], 4);
    check("dens_p64", counts[1], 8);
    check("dens_p128", counts[2], 16);
    check("dens_p255", counts[3], 32);
    check("dens_p0_a", counts[4], 0);
    check("dens_p0_b", counts[5], 0);

    // tick latency: counter at 0, pixel 16 spikes until cnt becomes 1
    set_pixels(16, 0, 0, 0, 0, 0);
    step(1);
    check("lat_pre", int'(spike[0]), 1);
    clk_cnt = 1'b1;
    step(1);
    check("lat_k", int'(spike[0]), 1);
    step(1);
    check("lat_k1", int'(spike[0]), 1);
    step(1);
    check("lat_k2", int'(spike[0]), 1);
    step(1);
    check("lat_k3", int'(spike[0]), 0);
    clk_cnt = 1'b0;
    step(3);

    check("pix_before", int'(spike[1]), 0);
    pixel[1] = 8'd255;
    check("pix_no_edge", int'(spike[1]), 0);
    step(1);
    check("pix_after", int'(spike[1]), 1);

    // wrap: 17 ticks from a fresh window leave cnt at 1
    rst_n = 1'b0;
    #1;
    check("async_rst_a", spike_vec(), 0);
    step(1);
    rst_n = 1'b1;
    set_pixels(16, 0, 32, 0, 0, 0);
    step(1);
    check("wrap_start", int'(spike[0]), 1);
    run_ticks(17);
    check("wrap_p16", int'(spike[0]), 0);
    check("wrap_p32", int'(spike[2]), 1);

    rst_n = 1'b0;
    #1;
    check("async_rst_b", spike_vec(), 0);
    step(2);
    check("rst_hold", spike_vec(), 0);
    rst_n = 1'b1;
    step(1);
    check("rst_p16", int'(spike[0]), 1);
    check("rst_p32", int'(spike[2]), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
